// File: rtl/FIFO_pkg.sv
// Shared FIFO-side definitions: word geometry, burst limit and the write
// arbiter state encoding used by the FIFO write-port arbiter.
package FIFO_pkg;

    localparam int FIFO_WIDTH = 16;
    localparam int FIFO_DEPTH = 8;
    localparam int MAX_BURST  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        STALL = 2'd2
    } arb_state_e;

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Round-robin winner search: starting at start_i and wrapping modulo
// NUM_REQ, return the first requesting index. Purely combinational.
module rr_pick #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   start_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   winner_o
);

    // Walk offsets from farthest to nearest so the nearest request wins.
    always_comb begin
        int sum;
        sum      = 0;
        found_o  = 1'b0;
        winner_o = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            sum = int'(start_i) + off;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            if (req_i[sum[IDX_W-1:0]]) begin
                found_o  = 1'b1;
                winner_o = sum[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// FIFO write-port arbiter: several producers share one FIFO write port.
// A round-robin pick opens a tenure of up to MAX_BURST words; the tenure
// stalls while the FIFO cannot take a word and ends when the owner stops
// requesting or the burst limit is reached. One bubble cycle per IDLE pass.
module fifo_wr_arb #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = FIFO_pkg::FIFO_WIDTH,
    parameter int MAX_BURST  = FIFO_pkg::MAX_BURST,
    localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_REQ-1:0]                  req,
    input  logic [NUM_REQ-1:0][FIFO_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]                  gnt,
    input  logic                                arb_en,
    input  logic                                full,
    input  logic                                almostfull,
    input  logic                                overflow,
    output logic                                wr_en,
    output logic [FIFO_WIDTH-1:0]               data_in,
    output logic [IDX_W-1:0]                    owner,
    output logic                                ovf_err,
    output logic [15:0]                         word_cnt
);

    import FIFO_pkg::*;

    localparam int              BC_W       = $clog2(MAX_BURST + 1);
    localparam logic [BC_W-1:0] LAST_BEAT  = BC_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

    arb_state_e              state_q, state_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [IDX_W-1:0]        lastOwner_q, lastOwner_d;
    logic [BC_W-1:0]         burstCnt_q, burstCnt_d;
    logic                    wrEn_q;
    logic [FIFO_WIDTH-1:0]   dataIn_q;
    logic [15:0]             wordCnt_q;
    logic                    ovfErr_q;

    logic                    allow;
    logic                    ownerReq;
    logic                    handshake;
    logic                    pickFound;
    logic [IDX_W-1:0]        pickIdx;
    logic [IDX_W-1:0]        searchStart;

    // A word already in flight into an almost-full FIFO takes the last slot,
    // so the next word must wait even though full has not risen yet.
    assign allow       = !full && !(almostfull && wrEn_q);
    assign ownerReq    = req[owner_q];
    assign handshake   = |(req & gnt);
    assign searchStart = (lastOwner_q == LAST_IDX) ? '0 : lastOwner_q + IDX_W'(1);

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req_i    (req),
        .start_i  (searchStart),
        .found_o  (pickFound),
        .winner_o (pickIdx)
    );

    // State and tenure bookkeeping registers; reset leaves requester 0 first in line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            lastOwner_q <= LAST_IDX;
            burstCnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lastOwner_q <= lastOwner_d;
            burstCnt_q  <= burstCnt_d;
        end
    end

    // Next-state logic: open tenures from IDLE, count beats, stall and release.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lastOwner_d = lastOwner_q;
        burstCnt_d  = burstCnt_q;
        case (state_q)
            IDLE: begin
                if (arb_en && pickFound) begin
                    owner_d    = pickIdx;
                    burstCnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                if (!ownerReq) begin
                    state_d     = IDLE;
                    lastOwner_d = owner_q;
                end else if (!allow) begin
                    state_d = STALL;
                end else begin
                    burstCnt_d = burstCnt_q + BC_W'(1);
                    if (burstCnt_q == LAST_BEAT) begin
                        state_d     = IDLE;
                        lastOwner_d = owner_q;
                    end
                end
            end
            STALL: begin
                if (!ownerReq) begin
                    state_d     = IDLE;
                    lastOwner_d = owner_q;
                end else if (allow) begin
                    state_d = BURST;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Grant is one-hot on the owner only while bursting and the FIFO can accept.
    always_comb begin
        gnt = '0;
        if ((state_q == BURST) && ownerReq && allow) begin
            gnt[owner_q] = 1'b1;
        end
    end

    // Write port, word counter and sticky overflow error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrEn_q    <= 1'b0;
            dataIn_q  <= '0;
            wordCnt_q <= '0;
            ovfErr_q  <= 1'b0;
        end else begin
            wrEn_q   <= handshake;
            ovfErr_q <= ovfErr_q | overflow;
            if (handshake) begin
                dataIn_q  <= req_data[owner_q];
                wordCnt_q <= wordCnt_q + 16'd1;
            end
        end
    end

    assign wr_en    = wrEn_q;
    assign data_in  = dataIn_q;
    assign owner    = owner_q;
    assign ovf_err  = ovfErr_q;
    assign word_cnt = wordCnt_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Scoreboard bench for fifo_wr_arb: producer queues feed the requesters,
// a small FIFO occupancy model drives the status flags, and a monitor
// checks every FIFO write against hand-ordered expected words.
module tb_fifo_wr_arb;

    localparam int NR    = 4;
    localparam int W     = 16;
    localparam int DEPTH = FIFO_pkg::FIFO_DEPTH;

    typedef struct {
        logic [W-1:0] data;
        logic [1:0]   owner;
    } exp_t;

    logic                 clk;
    logic                 rst_n;
    logic [NR-1:0]        req;
    logic [NR-1:0][W-1:0] reqData;
    logic [NR-1:0]        gnt;
    logic                 arbEn;
    logic                 full;
    logic                 almostFull;
    logic                 overflow;
    logic                 wr_en;
    logic [W-1:0]         data_in;
    logic [1:0]           owner;
    logic                 ovf_err;
    logic [15:0]          word_cnt;

    exp_t         expQ[$];
    logic [W-1:0] prodQ[NR][$];
    exp_t         monEntry;

    int assertCount = 0;
    int failCount   = 0;
    int writeCount  = 0;
    int fifoCount   = 0;
    int readReq     = 0;
    bit autoDrain   = 1'b1;
    bit forceOvf    = 1'b0;
    bit modelOvf    = 1'b0;
    int base;

    fifo_wr_arb #(
        .NUM_REQ (NR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_data   (reqData),
        .gnt        (gnt),
        .arb_en     (arbEn),
        .full       (full),
        .almostfull (almostFull),
        .overflow   (overflow),
        .wr_en      (wr_en),
        .data_in    (data_in),
        .owner      (owner),
        .ovf_err    (ovf_err),
        .word_cnt   (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, reports a failure line on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Queue a word for a producer to offer.
    task automatic applyStimulus(input int idx, input logic [W-1:0] data);
        prodQ[idx].push_back(data);
    endtask

    // Queue the write the FIFO should see next.
    task automatic pushExpected(input logic [W-1:0] data, input logic [1:0] own);
        exp_t ent;
        ent.data  = data;
        ent.owner = own;
        expQ.push_back(ent);
    endtask

    function automatic bit anyPending();
        for (int i = 0; i < NR; i++) begin
            if (prodQ[i].size() != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Wait for all offered words to be written and checked, bounded.
    task automatic waitDrain(input string name, input int budget);
        int n;
        n = 0;
        while ((expQ.size() != 0 || anyPending()) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, {31'd0, (expQ.size() == 0 && !anyPending())}, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    // Wait until the monitor has seen a given number of writes, bounded.
    task automatic waitWrites(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (writeCount < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput(name, {31'd0, (writeCount >= target)}, 32'd1);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < NR; i++) prodQ[i].delete();
        expQ.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Producers and FIFO occupancy model, updated just after each rising edge.
    initial begin : producer
        logic [NR-1:0] hs;
        logic          wrSeen;
        req        = '0;
        reqData    = '0;
        full       = 1'b0;
        almostFull = 1'b0;
        overflow   = 1'b0;
        forever begin
            @(posedge clk);
            hs     = req & gnt;
            wrSeen = wr_en;
            #1;
            for (int i = 0; i < NR; i++) begin
                if (hs[i] && prodQ[i].size() > 0) void'(prodQ[i].pop_front());
            end
            modelOvf = 1'b0;
            if (autoDrain) begin
                fifoCount = 0;
            end else begin
                if (wrSeen) begin
                    if (fifoCount >= DEPTH) modelOvf = 1'b1;
                    else fifoCount++;
                end
                fifoCount = (fifoCount > readReq) ? fifoCount - readReq : 0;
                readReq   = 0;
            end
            for (int i = 0; i < NR; i++) begin
                req[i]     = (prodQ[i].size() > 0);
                reqData[i] = (prodQ[i].size() > 0) ? prodQ[i][0] : '0;
            end
            full       = (fifoCount >= DEPTH);
            almostFull = (fifoCount >= DEPTH - 1);
            overflow   = forceOvf || modelOvf;
        end
    end

    // Monitor: every FIFO write pops the scoreboard and is compared.
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            writeCount++;
            if (expQ.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL unexpected_write: got data 0x%0h owner %0d, expected no write", data_in, owner);
            end else begin
                monEntry = expQ.pop_front();
                checkOutput("wr_data", {16'd0, data_in}, {16'd0, monEntry.data});
                checkOutput("wr_owner", {30'd0, owner}, {30'd0, monEntry.owner});
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        rst_n = 1'b0;
        arbEn = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_wr_en", {31'd0, wr_en}, 32'd0);
        checkOutput("rst_data_in", {16'd0, data_in}, 32'd0);
        checkOutput("rst_owner", {30'd0, owner}, 32'd0);
        checkOutput("rst_word_cnt", {16'd0, word_cnt}, 32'd0);
        checkOutput("rst_ovf_err", {31'd0, ovf_err}, 32'd0);
        checkOutput("rst_gnt", {28'd0, gnt}, 32'd0);
        rst_n = 1'b1;

        $display("[TB] single requester 2, six words");
        for (int k = 0; k < 6; k++) begin
            applyStimulus(2, 16'(16'hA0 + k));
            pushExpected(16'(16'hA0 + k), 2'd2);
        end
        waitDrain("t1_drain", 60);
        checkOutput("t1_word_cnt", {16'd0, word_cnt}, 32'd6);

        $display("[TB] four requesters after reset");
        doReset();
        for (int r = 0; r < NR; r++) begin
            for (int k = 0; k < 4; k++) applyStimulus(r, 16'(32'h1000 + r * 256 + k));
        end
        for (int k = 4; k < 8; k++) applyStimulus(0, 16'(32'h1000 + k));
        for (int r = 0; r < NR; r++) begin
            for (int k = 0; k < 4; k++) pushExpected(16'(32'h1000 + r * 256 + k), 2'(r));
        end
        for (int k = 4; k < 8; k++) pushExpected(16'(32'h1000 + k), 2'd0);
        waitDrain("t2_drain", 200);
        checkOutput("t2_word_cnt", {16'd0, word_cnt}, 32'd20);

        $display("[TB] requester 1 drops after two words");
        applyStimulus(1, 16'h2100);
        applyStimulus(1, 16'h2101);
        applyStimulus(2, 16'h2200);
        applyStimulus(2, 16'h2201);
        applyStimulus(0, 16'h2000);
        pushExpected(16'h2100, 2'd1);
        pushExpected(16'h2101, 2'd1);
        pushExpected(16'h2200, 2'd2);
        pushExpected(16'h2201, 2'd2);
        pushExpected(16'h2000, 2'd0);
        waitDrain("t4_drain", 60);
        checkOutput("t4_word_cnt", {16'd0, word_cnt}, 32'd25);

        $display("[TB] burst into near-full FIFO");
        autoDrain = 1'b0;
        fifoCount = 6;
        base      = writeCount;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 16'(16'h3000 + k));
            pushExpected(16'(16'h3000 + k), 2'd0);
        end
        waitWrites("t3_two_writes", base + 2, 30);
        repeat (4) @(negedge clk);
        checkOutput("t3_stall_writes", writeCount - base, 32'd2);
        checkOutput("t3_stall_gnt", {28'd0, gnt}, 32'd0);
        checkOutput("t3_stall_wr_en", {31'd0, wr_en}, 32'd0);
        checkOutput("t3_stall_pending", expQ.size(), 32'd2);
        readReq = 4;
        waitDrain("t3_drain", 40);
        checkOutput("t3_ovf_err", {31'd0, ovf_err}, 32'd0);
        autoDrain = 1'b1;
        checkOutput("t3_word_cnt", {16'd0, word_cnt}, 32'd29);

        $display("[TB] arb_en low blocks new tenures");
        arbEn = 1'b0;
        base  = writeCount;
        applyStimulus(3, 16'h4000);
        applyStimulus(3, 16'h4001);
        pushExpected(16'h4000, 2'd3);
        pushExpected(16'h4001, 2'd3);
        repeat (6) @(negedge clk);
        checkOutput("t6_blocked_writes", writeCount - base, 32'd0);
        checkOutput("t6_blocked_gnt", {28'd0, gnt}, 32'd0);
        arbEn = 1'b1;
        waitDrain("t6_drain", 40);
        checkOutput("t6_word_cnt", {16'd0, word_cnt}, 32'd31);

        $display("[TB] overflow pulse");
        checkOutput("t7_ovf_before", {31'd0, ovf_err}, 32'd0);
        @(negedge clk);
        forceOvf = 1'b1;
        @(negedge clk);
        forceOvf = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("t7_ovf_set", {31'd0, ovf_err}, 32'd1);
        repeat (5) @(negedge clk);
        checkOutput("t7_ovf_sticky", {31'd0, ovf_err}, 32'd1);

        $display("[TB] reset during requester 3 burst");
        base = writeCount;
        for (int k = 0; k < 4; k++) applyStimulus(3, 16'(16'h5300 + k));
        pushExpected(16'h5300, 2'd3);
        pushExpected(16'h5301, 2'd3);
        waitWrites("t5_two_writes", base + 2, 30);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_wr_en", {31'd0, wr_en}, 32'd0);
        checkOutput("t5_rst_data_in", {16'd0, data_in}, 32'd0);
        checkOutput("t5_rst_owner", {30'd0, owner}, 32'd0);
        checkOutput("t5_rst_word_cnt", {16'd0, word_cnt}, 32'd0);
        checkOutput("t5_rst_ovf_err", {31'd0, ovf_err}, 32'd0);
        checkOutput("t5_rst_gnt", {28'd0, gnt}, 32'd0);
        for (int i = 0; i < NR; i++) prodQ[i].delete();
        expQ.delete();
        applyStimulus(3, 16'h5310);
        applyStimulus(0, 16'h5000);
        pushExpected(16'h5000, 2'd0);
        pushExpected(16'h5310, 2'd3);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        waitDrain("t5_drain", 40);
        checkOutput("t5_word_cnt", {16'd0, word_cnt}, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
